// File: rtl/quantum_scheduler_pkg.sv
// Shared state encoding and size defaults for the round-robin quantum scheduler.
package quantum_scheduler_pkg;
  localparam int NUM_TASKS_DEF = 4;
  localparam int TASK_W_DEF    = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_IRQ    = 2'd2,
    S_SWITCH = 2'd3
  } sched_state_t;
endpackage

// File: rtl/quantum_scheduler_if.sv
// Scheduler bundle: OS ready mask, CPU IRQ handshake and deadline-timer control.
// SCHED_YIELD_EN adds yield_req / preempt_cause.
interface quantum_scheduler_if #(
  parameter int NUM_TASKS = quantum_scheduler_pkg::NUM_TASKS_DEF,
  parameter int TASK_W    = quantum_scheduler_pkg::TASK_W_DEF
);
  logic                 enable;
  logic [NUM_TASKS-1:0] task_ready;
  logic                 dl_timeout;
  logic                 irq_ack;
  logic                 ctx_done;
  logic                 dl_start;
  logic                 dl_stop;
  logic                 preempt_irq;
  logic [TASK_W-1:0]    cur_task;
  logic [TASK_W-1:0]    next_task;
  logic                 running;
`ifdef SCHED_YIELD_EN
  logic                 yield_req;
  logic                 preempt_cause;
`endif

  modport master (
`ifdef SCHED_YIELD_EN
    input  yield_req,
    output preempt_cause,
`endif
    input  enable, task_ready, dl_timeout, irq_ack, ctx_done,
    output dl_start, dl_stop, preempt_irq, cur_task, next_task, running
  );

  modport slave (
`ifdef SCHED_YIELD_EN
    output yield_req,
    input  preempt_cause,
`endif
    output enable, task_ready, dl_timeout, irq_ack, ctx_done,
    input  dl_start, dl_stop, preempt_irq, cur_task, next_task, running
  );
endinterface

// File: rtl/quantum_scheduler_rr_pick.sv
// Combinational round-robin finder: first ready task after cur_task, cur_task last.
// from_zero starts the search at index 0; pick falls back to cur_task when nothing is ready.
module rr_pick #(
  parameter int NUM_TASKS = 4,
  parameter int TASK_W    = 2
) (
  input  logic [NUM_TASKS-1:0] task_ready,
  input  logic [TASK_W-1:0]    cur_task,
  input  logic                 from_zero,
  output logic [TASK_W-1:0]    pick,
  output logic                 any
);
  logic [TASK_W-1:0] base;
  logic [TASK_W-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest ready slot wins.
  always_comb begin
    base = from_zero ? TASK_W'(NUM_TASKS - 1) : cur_task;
    pick = cur_task;
    idx  = '0;
    for (int off = NUM_TASKS; off >= 1; off--) begin
      idx = TASK_W'((int'(base) + off) % NUM_TASKS);
      if (task_ready[idx]) pick = idx;
    end
  end

  assign any = |task_ready;
endmodule

// File: rtl/quantum_scheduler.sv
// Round-robin time-slice scheduler driving one deadline timer and the CPU preempt IRQ.
// Optional SCHED_YIELD_EN: voluntary yield_req preempts like a timeout, reported via preempt_cause.
module quantum_scheduler
  import quantum_scheduler_pkg::*;
#(
  parameter int NUM_TASKS = NUM_TASKS_DEF,
  parameter int TASK_W    = $clog2(NUM_TASKS)
) (
  input  logic                cpu_clk,
  input  logic                reset,
  quantum_scheduler_if.master bus
);
  sched_state_t      state;
  logic              dl_start, dl_stop, preempt_irq, running;
  logic [TASK_W-1:0] cur_task, next_task, pick;
  logic              any, tmo_eff, preempt;

  rr_pick #(.NUM_TASKS(NUM_TASKS), .TASK_W(TASK_W)) u_pick (
    .task_ready (bus.task_ready),
    .cur_task   (cur_task),
    .from_zero  (state == S_IDLE),
    .pick       (pick),
    .any        (any)
  );

  // Timer count is stale in the arming cycle, so its expiry is not trusted then.
  assign tmo_eff = bus.dl_timeout & ~dl_start;

`ifdef SCHED_YIELD_EN
  logic cause;
  assign preempt           = tmo_eff | bus.yield_req;
  assign bus.preempt_cause = cause;
`else
  assign preempt = tmo_eff;
`endif

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state       <= S_IDLE;
      dl_start    <= 1'b0;
      dl_stop     <= 1'b0;
      preempt_irq <= 1'b0;
      running     <= 1'b0;
      cur_task    <= '0;
      next_task   <= '0;
`ifdef SCHED_YIELD_EN
      cause       <= 1'b0;
`endif
    end else begin
      dl_start <= 1'b0;
      dl_stop  <= 1'b0;
      case (state)
        S_IDLE: if (bus.enable && any) begin
          cur_task <= pick;
          dl_start <= 1'b1;
          running  <= 1'b1;
          state    <= S_RUN;
        end
        S_RUN: if (!bus.enable) begin
          dl_stop <= 1'b1;
          running <= 1'b0;
          state   <= S_IDLE;
        end else if (preempt) begin
          dl_stop     <= 1'b1;
          preempt_irq <= 1'b1;
          next_task   <= any ? pick : cur_task;
`ifdef SCHED_YIELD_EN
          cause       <= ~tmo_eff;
`endif
          state       <= S_IRQ;
        end
        S_IRQ: if (bus.irq_ack) begin
          preempt_irq <= 1'b0;
          state       <= S_SWITCH;
        end
        S_SWITCH: if (bus.ctx_done) begin
          if (bus.task_ready[next_task] && bus.enable) begin
            cur_task <= next_task;
            dl_start <= 1'b1;
            state    <= S_RUN;
          end else begin
            running <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dl_start    = dl_start;
  assign bus.dl_stop     = dl_stop;
  assign bus.preempt_irq = preempt_irq;
  assign bus.cur_task    = cur_task;
  assign bus.next_task   = next_task;
  assign bus.running     = running;
endmodule

// File: tb/tb_quantum_scheduler.sv
// Directed vector table plus randomized run against a behavioural scheduler model.
module tb_quantum_scheduler;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, en = 1'b0, to = 1'b0, ack = 1'b0, ctx = 1'b0, yl = 1'b0;
  logic [3:0] rdy = 4'b0000;

  quantum_scheduler_if #(.NUM_TASKS(N), .TASK_W(2)) bus ();

  assign bus.enable     = en;
  assign bus.task_ready = rdy;
  assign bus.dl_timeout = to;
  assign bus.irq_ack    = ack;
  assign bus.ctx_done   = ctx;
`ifdef SCHED_YIELD_EN
  assign bus.yield_req  = yl;
`endif

  quantum_scheduler #(.NUM_TASKS(N), .TASK_W(2)) dut (
    .cpu_clk (clk),
    .reset   (rst),
    .bus     (bus)
  );

  int passed = 0, total = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: walk the ring starting just after cur (or at 0), cur itself last.
  function automatic int ref_pick(logic [3:0] r, int cur, bit from_zero);
    for (int k = 0; k < N; k++) begin
      int i = from_zero ? k : (cur + 1 + k) % N;
      if (r[i]) return i;
    end
    return cur;
  endfunction

  typedef enum {M_OFF, M_ACTIVE, M_WAIT_ACK, M_WAIT_CTX} mphase_e;
  mphase_e mph = M_OFF;
  bit m_start = 0, m_stop = 0, m_irq = 0, m_run = 0, m_cause = 0;
  int m_cur = 0, m_next = 0;

  task automatic model_update();
    bit was_start = m_start;
    bit fire_t;
    m_start = 0;
    m_stop  = 0;
    if (rst) begin
      mph = M_OFF; m_irq = 0; m_run = 0; m_cur = 0; m_next = 0; m_cause = 0;
    end else begin
      case (mph)
        M_OFF: if (en && rdy != 0) begin
          m_cur = ref_pick(rdy, 0, 1); m_start = 1; m_run = 1; mph = M_ACTIVE;
        end
        M_ACTIVE: begin
          fire_t = to && !was_start;
          if (!en) begin
            m_stop = 1; m_run = 0; mph = M_OFF;
          end else if (fire_t || yl) begin
            m_stop = 1; m_irq = 1; m_next = ref_pick(rdy, m_cur, 0);
            m_cause = !fire_t; mph = M_WAIT_ACK;
          end
        end
        M_WAIT_ACK: if (ack) begin m_irq = 0; mph = M_WAIT_CTX; end
        M_WAIT_CTX: if (ctx) begin
          if (rdy[m_next] && en) begin m_cur = m_next; m_start = 1; mph = M_ACTIVE; end
          else begin m_run = 0; mph = M_OFF; end
        end
        default: mph = M_OFF;
      endcase
    end
  endtask

  function automatic logic [7:0] dut_out();
    return {bus.dl_start, bus.dl_stop, bus.preempt_irq, bus.cur_task, bus.next_task, bus.running};
  endfunction

  function automatic logic [7:0] model_out();
    return {m_start, m_stop, m_irq, 2'(m_cur), 2'(m_next), m_run};
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic r, e; logic [3:0] rd; logic t, a, c;
    logic [7:0] exp;
  } vec_t;
  vec_t vq[$];

  task automatic add(bit r, bit e, logic [3:0] rd, bit t, bit a, bit c,
                     bit st, bit sp, bit irq, int cur, int nxt, bit run);
    vec_t v;
    v.r = r; v.e = e; v.rd = rd; v.t = t; v.a = a; v.c = c;
    v.exp = {st, sp, irq, 2'(cur), 2'(nxt), run};
    vq.push_back(v);
  endtask

  initial begin
    //  r e  rdy    t a c   start stop irq cur nxt run
    add(1,0,4'b0000,0,0,0,  0,0,0, 0,0, 0);
    add(0,1,4'b1010,0,0,0,  1,0,0, 1,0, 1);
    add(0,1,4'b1010,1,0,0,  0,0,0, 1,0, 1);
    add(0,1,4'b1010,1,0,0,  0,1,1, 1,3, 1);
    add(0,1,4'b1010,1,0,0,  0,0,1, 1,3, 1);
    add(0,1,4'b1010,0,1,0,  0,0,0, 1,3, 1);
    add(0,1,4'b1010,0,0,1,  1,0,0, 3,3, 1);
    add(0,1,4'b1000,0,0,0,  0,0,0, 3,3, 1);
    add(0,1,4'b1000,1,0,0,  0,1,1, 3,3, 1);
    add(0,1,4'b1000,0,1,0,  0,0,0, 3,3, 1);
    add(0,1,4'b1000,0,0,1,  1,0,0, 3,3, 1);
    add(0,1,4'b0000,0,0,0,  0,0,0, 3,3, 1);
    add(0,1,4'b0000,1,0,0,  0,1,1, 3,3, 1);
    add(0,1,4'b0000,0,1,0,  0,0,0, 3,3, 1);
    add(0,1,4'b0000,0,0,1,  0,0,0, 3,3, 0);
    add(0,1,4'b0000,0,0,0,  0,0,0, 3,3, 0);
    add(0,1,4'b0100,0,0,0,  1,0,0, 2,3, 1);
    add(0,0,4'b0100,1,0,0,  0,1,0, 2,3, 0);
    add(0,0,4'b0100,0,0,0,  0,0,0, 2,3, 0);
    add(0,1,4'b0011,0,0,0,  1,0,0, 0,3, 1);
    add(0,1,4'b0011,1,0,0,  0,0,0, 0,3, 1);
    add(0,1,4'b0011,1,0,0,  0,1,1, 0,1, 1);
    add(1,1,4'b0011,1,0,0,  0,0,0, 0,0, 0);
    add(0,0,4'b0000,1,1,1,  0,0,0, 0,0, 0);
    add(0,1,4'b0010,0,0,0,  1,0,0, 1,0, 1);
    add(0,1,4'b0010,0,0,0,  0,0,0, 1,0, 1);
    add(0,1,4'b0110,1,0,0,  0,1,1, 1,2, 1);
    add(0,0,4'b0110,0,1,0,  0,0,0, 1,2, 1);
    add(0,0,4'b0110,0,0,1,  0,0,0, 1,2, 0);

    #1;
    foreach (vq[i]) begin
      rst = vq[i].r; en = vq[i].e; rdy = vq[i].rd;
      to = vq[i].t; ack = vq[i].a; ctx = vq[i].c; yl = 1'b0;
      step();
      chk($sformatf("vec%0d", i), dut_out(), vq[i].exp);
    end

`ifdef SCHED_YIELD_EN
    rst = 1; en = 0; rdy = 0; to = 0; ack = 0; ctx = 0; yl = 0;
    step();
    rst = 0; en = 1; rdy = 4'b0011;
    step();
    yl = 1;
    step();
    chk("yield_cause", bus.preempt_cause, 1);
    chk("yield_next", bus.next_task, 1);
    chk("yield_irq", bus.preempt_irq, 1);
    yl = 0; ack = 1;
    step();
    ack = 0; ctx = 1;
    step();
    chk("yield_launch", {bus.dl_start, bus.cur_task}, {1'b1, 2'd1});
    ctx = 0;
    step();
    yl = 1; to = 1;
    step();
    chk("both_cause", bus.preempt_cause, 0);
    chk("both_next", bus.next_task, 0);
    yl = 0; to = 0;
`endif

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(63) == 0);
      en  = ($urandom_range(15) != 0);
      rdy = 4'($urandom_range(15));
      to  = ($urandom_range(3) == 0);
      ack = ($urandom_range(2) == 0);
      ctx = ($urandom_range(2) == 0);
`ifdef SCHED_YIELD_EN
      yl  = ($urandom_range(7) == 0);
`endif
      step();
      chk($sformatf("rand%0d", n), dut_out(), model_out());
      chk($sformatf("excl%0d", n), bus.dl_start & bus.dl_stop, 0);
`ifdef SCHED_YIELD_EN
      chk($sformatf("cause%0d", n), bus.preempt_cause, m_cause);
`endif
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
